alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//  Sequencer that owns the shared add/subtract ALU (INA/INB/CIN/BCD/SBC -> OUT/N/Z/C/V).
//  Accepts one request at a time over a valid/ready handshake and maps the opcode onto ALU inputs.
//  Runs one ALU pass for 8-bit ops and two passes (low byte, then high byte) for 16-bit address ops.
//  Owns the N/V/Z/C status bits; sits between the decoder and the register file.
// PARAMETERS
//  RESET_P   4'b0000  reset value of {N,V,Z,C}
//  OPT_BCD   1        0 forces ALU_BCD=0 for every op
// PORTS
//  CLK        in   1  clock
//  RST_N      in   1  async active-low reset
//  REQ_VALID  in   1  request present
//  REQ_READY  out  1  high only in IDLE
//  REQ_OP     in   4  0 ADC,1 SBC,2 CMP,3 INC,4 DEC,5 ASL,6 ROL,8 IDX16,9 REL16; other codes illegal
//  REQ_A      in   8  operand A / address low byte
//  REQ_AH     in   8  address high byte (16-bit ops only)
//  REQ_B      in   8  operand B / index / signed offset
//  FLAG_D     in   1  decimal flag, sampled at accept
//  FLG_WE     in   1  direct flag write (PLP/SEC/CLV path)
//  FLG_IN     in   4  {N,V,Z,C} for FLG_WE
//  ALU_A,ALU_B out 8  registered ALU operands
//  ALU_CIN,ALU_BCD,ALU_SBC out 1 registered ALU controls
//  ALU_OUT    in   8  ALU result (combinational from ALU_* regs)
//  ALU_N,ALU_Z,ALU_C,ALU_V in 1 ALU flags
//  RES_VALID  out  1  result held
//  RES_READY  in   1  consumer takes result
//  RES_LO,RES_HI out 8 result bytes (RES_HI=0 for 8-bit ops)
//  PAGE_X     out  1  16-bit op: RES_HI != REQ_AH
//  RES_ERR    out  1  illegal opcode completed
//  P_N,P_V,P_Z,P_C out 1 status bits
// BEHAVIOUR
//  Reset: state IDLE, REQ_READY=1, RES_VALID=0, RES_*/PAGE_X/RES_ERR/ALU_*=0, {N,V,Z,C}=RESET_P.
//  States: IDLE -(VALID&READY)-> LO; LO -8bit/illegal-> DONE; LO -16bit-> HI -> DONE; DONE -RES_READY-> IDLE.
//  Accept edge loads ALU_* regs for the low pass; REQ_*/FLAG_D ignored afterwards.
//  LO drive: ADC A,B,CIN=P_C,BCD=D; SBC A,B,CIN=P_C,BCD=D,SBC=1; CMP A,B,CIN=1,SBC=1;
//   INC A,B=1,CIN=0; DEC A,B=1,CIN=1,SBC=1; ASL A,A,CIN=0; ROL A,A,CIN=P_C;
//   IDX16/REL16 A,B,CIN=0. BCD=0 and SBC=0 wherever not listed.
//  Edge leaving LO: RES_LO<=ALU_OUT. Flags: ADC/SBC NZCV; CMP/ASL/ROL NZC; INC/DEC NZ; others none.
//  Illegal op: RES_LO=REQ_A, RES_ERR=1, flags untouched. RES_ERR clears at next accept.
//  HI: ALU_A=AH, ALU_B=0x00 (IDX16) or {8{B[7]}} (REL16), CIN=low-pass ALU_C, BCD=SBC=0.
//   Edge leaving HI: RES_HI<=ALU_OUT, PAGE_X set. Flags untouched.
//  Latency: RES_VALID rises 2 edges after accept (8-bit), 3 edges (16-bit); min 3/4 cycles per op.
//  DONE: RES_* stable while RES_VALID && !RES_READY; RES_VALID falls on edge with RES_READY.
//  FLG_WE honoured in any state. Same edge as an op flag update: op wins for bits it writes, FLG_IN for the rest.
//  RST_N low mid-op: immediate IDLE, request dropped, all outputs to reset values.
// TESTING
//  ADC A=0x0D B=0xD3 C=1 D=0 -> RES_LO=0xE1, N1 Z0 C0 V0, RES_VALID 2 edges after accept.
//  ADC BCD A=0x79 B=0x14 C=0 D=1 -> RES_LO=0x93, C=0; same with OPT_BCD=0 -> 0x8D.
//  SBC A=0x05 B=0x06 C=1 -> 0xFF, N1 C0 V0; CMP A=B=0x05 with V preset 1 -> Z1 C1 N0, V stays 1.
//  IDX16 0x12F0+0x20 -> RES=0x1310, PAGE_X=1; REL16 0x1305+0xFA -> 0x12FF, PAGE_X=1; flags untouched, 3-edge latency.
//  RES_READY=0 for 5 cycles -> RES_* stable, REQ_READY=0; FLG_WE with FLG_IN=4'b1111 on ASL-complete edge (A=0x80) -> N0 V1 Z1 C1.
//  RST_N low during HI -> RES_VALID=0, flags=RESET_P, REQ_READY=1; illegal op 0xF with A=0x42 -> RES_LO=0x42, RES_ERR=1.

Source files
------------

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// alu_seq : sequences the shared add/subtract ALU and owns the N/V/Z/C bits
// Revision: 1.0
// ============================================================================
module alu_seq #(
  parameter logic [3:0] RESET_P = 4'b0000,
  parameter int         OPT_BCD = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic [7:0] req_a,
  input  logic [7:0] req_ah,
  input  logic [7:0] req_b,
  input  logic       flag_d,
  input  logic       flg_we,
  input  logic [3:0] flg_in,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_cin,
  output logic       alu_bcd,
  output logic       alu_sbc,
  input  logic [7:0] alu_out,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       alu_v,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_lo,
  output logic [7:0] res_hi,
  output logic       page_x,
  output logic       res_err,
  output logic       p_n,
  output logic       p_v,
  output logic       p_z,
  output logic       p_c
);

  localparam logic [3:0] c_OP_ADC   = 4'd0;
  localparam logic [3:0] c_OP_SBC   = 4'd1;
  localparam logic [3:0] c_OP_CMP   = 4'd2;
  localparam logic [3:0] c_OP_INC   = 4'd3;
  localparam logic [3:0] c_OP_DEC   = 4'd4;
  localparam logic [3:0] c_OP_ASL   = 4'd5;
  localparam logic [3:0] c_OP_ROL   = 4'd6;
  localparam logic [3:0] c_OP_IDX16 = 4'd8;
  localparam logic [3:0] c_OP_REL16 = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     r_state, w_state_next;
  logic [3:0] r_op;
  logic [7:0] r_ah;
  logic       r_bsign;
  logic [7:0] r_alu_a, r_alu_b;
  logic       r_alu_cin, r_alu_bcd, r_alu_sbc;
  logic       r_res_valid, r_page_x, r_res_err;
  logic [7:0] r_res_lo, r_res_hi;
  logic [3:0] r_flags;  // {N,V,Z,C}

  logic       w_is16, w_legal;
  logic [7:0] w_lo_b;
  logic       w_lo_cin, w_lo_bcd, w_lo_sbc;
  logic [3:0] w_op_mask, w_op_val, w_flags_next;

  assign w_is16  = (r_op == c_OP_IDX16) || (r_op == c_OP_REL16);
  assign w_legal = (r_op <= c_OP_ROL) || w_is16;

  // Low-pass ALU controls, decoded straight from the request at accept time
  always_comb begin
    w_lo_b   = req_b;
    w_lo_cin = 1'b0;
    w_lo_bcd = 1'b0;
    w_lo_sbc = 1'b0;
    case (req_op)
      c_OP_ADC: begin
        w_lo_cin = r_flags[0];
        w_lo_bcd = flag_d;
      end
      c_OP_SBC: begin
        w_lo_cin = r_flags[0];
        w_lo_bcd = flag_d;
        w_lo_sbc = 1'b1;
      end
      c_OP_CMP: begin
        w_lo_cin = 1'b1;
        w_lo_sbc = 1'b1;
      end
      c_OP_INC: w_lo_b = 8'h01;
      c_OP_DEC: begin
        w_lo_b   = 8'h01;
        w_lo_cin = 1'b1;
        w_lo_sbc = 1'b1;
      end
      c_OP_ASL: w_lo_b = req_a;
      c_OP_ROL: begin
        w_lo_b   = req_a;
        w_lo_cin = r_flags[0];
      end
      c_OP_IDX16, c_OP_REL16: w_lo_b = req_b;
      default: w_lo_b = 8'h00;
    endcase
    if (OPT_BCD == 0) w_lo_bcd = 1'b0;
  end

  // Op-driven flag writes take priority over the direct write, bit by bit
  always_comb begin
    w_op_mask = 4'b0000;
    w_op_val  = {alu_n, alu_v, alu_z, alu_c};
    if (r_state == S_LO) begin
      case (r_op)
        c_OP_ADC, c_OP_SBC:           w_op_mask = 4'b1111;
        c_OP_CMP, c_OP_ASL, c_OP_ROL: w_op_mask = 4'b1011;
        c_OP_INC, c_OP_DEC:           w_op_mask = 4'b1010;
        default:                      w_op_mask = 4'b0000;
      endcase
    end
    w_flags_next = (w_op_mask & w_op_val) |
                   (~w_op_mask & (flg_we ? flg_in : r_flags));
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (req_valid) w_state_next = S_LO;
      S_LO:    w_state_next = w_is16 ? S_HI : S_DONE;
      S_HI:    w_state_next = S_DONE;
      S_DONE:  if (res_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op        <= 4'd0;
      r_ah        <= 8'h00;
      r_bsign     <= 1'b0;
      r_alu_a     <= 8'h00;
      r_alu_b     <= 8'h00;
      r_alu_cin   <= 1'b0;
      r_alu_bcd   <= 1'b0;
      r_alu_sbc   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_lo    <= 8'h00;
      r_res_hi    <= 8'h00;
      r_page_x    <= 1'b0;
      r_res_err   <= 1'b0;
      r_flags     <= RESET_P;
    end else begin
      r_flags <= w_flags_next;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op      <= req_op;
            r_ah      <= req_ah;
            r_bsign   <= req_b[7];
            r_alu_a   <= req_a;
            r_alu_b   <= w_lo_b;
            r_alu_cin <= w_lo_cin;
            r_alu_bcd <= w_lo_bcd;
            r_alu_sbc <= w_lo_sbc;
            r_res_err <= 1'b0;
          end
        end
        S_LO: begin
          // Illegal ops echo operand A, which is still held in the ALU A register
          r_res_lo  <= w_legal ? alu_out : r_alu_a;
          r_res_err <= ~w_legal;
          if (w_is16) begin
            r_alu_a   <= r_ah;
            r_alu_b   <= (r_op == c_OP_REL16) ? {8{r_bsign}} : 8'h00;
            r_alu_cin <= alu_c;
            r_alu_bcd <= 1'b0;
            r_alu_sbc <= 1'b0;
          end else begin
            r_res_hi    <= 8'h00;
            r_page_x    <= 1'b0;
            r_res_valid <= 1'b1;
          end
        end
        S_HI: begin
          r_res_hi    <= alu_out;
          r_page_x    <= (alu_out != r_alu_a);
          r_res_valid <= 1'b1;
        end
        S_DONE: begin
          if (res_ready) r_res_valid <= 1'b0;
        end
        default: r_res_valid <= 1'b0;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_cin   = r_alu_cin;
  assign alu_bcd   = r_alu_bcd;
  assign alu_sbc   = r_alu_sbc;
  assign res_valid = r_res_valid;
  assign res_lo    = r_res_lo;
  assign res_hi    = r_res_hi;
  assign page_x    = r_page_x;
  assign res_err   = r_res_err;
  assign {p_n, p_v, p_z, p_c} = r_flags;

endmodule
`default_nettype wire
